// File: rtl/seg_capture.sv
// seg_capture: observes a multiplexed, active-low 7-segment bus and debounces each
// {segment, select} pattern. It decodes stable patterns back to 4-bit digit codes,
// assembles eight slots in a shadow frame and publishes each complete frame atomically.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   seg_in[6:0]  active-low segments, [6]=a .. [0]=g
//   an_in[7:0]   active-low digit selects, bit i low = slot i driven
//   digits[31:0] published frame, slot i at [4i+3:4i]
//   blank[7:0]   published per-slot blank flags (all segments off)
//   err[7:0]     published per-slot undecodable-pattern flags
//   frame_valid  one-cycle pulse when digits/blank/err update
//   an_err       one-cycle pulse when a stable pattern has more than one select low
module seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [7:0]  an_in,
    output logic [31:0] digits,
    output logic [7:0]  blank,
    output logic [7:0]  err,
    output logic        frame_valid,
    output logic        an_err
);

    localparam logic [7:0]  CntMax     = 8'(STABLE_CYCLES);
    localparam logic [7:0]  CntLast    = 8'(STABLE_CYCLES - 1);
    localparam logic [14:0] IdleSample = {7'h7F, 8'hFF};

    // Stability filter state
    logic [14:0] r_sample;
    logic [7:0]  r_cnt;
    logic        r_done;

    // Shadow frame being assembled
    logic [31:0] r_sh_digits;
    logic [7:0]  r_sh_blank;
    logic [7:0]  r_sh_err;
    logic [7:0]  r_seen;

    // Published outputs
    logic [31:0] r_digits;
    logic [7:0]  r_blank;
    logic [7:0]  r_err;
    logic        r_frame_valid;
    logic        r_an_err;

    logic [14:0] w_sample;
    logic        w_same;
    logic        w_capture;
    logic [7:0]  w_an_low;
    logic        w_one_hot;
    logic        w_multi;
    logic [2:0]  w_slot;
    logic [3:0]  w_code;
    logic        w_blank_bit;
    logic        w_err_bit;
    logic        w_publish;
    logic [31:0] w_sh_digits_d;
    logic [7:0]  w_sh_blank_d;
    logic [7:0]  w_sh_err_d;
    logic [7:0]  w_seen_d;

    assign w_sample  = {seg_in, an_in};
    assign w_same    = (w_sample == r_sample);
    // Fires on the edge where the count would reach STABLE_CYCLES; done blocks repeats
    // for the rest of the dwell.
    assign w_capture = w_same && (r_cnt == CntLast) && !r_done;

    // Select decode: one low bit names a slot, several low bits are a bus error.
    assign w_an_low  = ~an_in;
    assign w_one_hot = (w_an_low != 8'h00) && ((w_an_low & (w_an_low - 8'h01)) == 8'h00);
    assign w_multi   = (w_an_low != 8'h00) && !w_one_hot;

    always_comb begin
        w_slot = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_an_low[i]) begin
                w_slot = 3'(i);
            end
        end
    end

    // Segment decode, pattern order abcdefg, 0 = segment lit
    always_comb begin
        w_code      = 4'hE;
        w_blank_bit = 1'b0;
        w_err_bit   = 1'b0;
        case (seg_in)
            7'b0000001: w_code = 4'h0;
            7'b1001111: w_code = 4'h1;
            7'b0010010: w_code = 4'h2;
            7'b0000110: w_code = 4'h3;
            7'b1001100: w_code = 4'h4;
            7'b0100100: w_code = 4'h5;
            7'b0100000: w_code = 4'h6;
            7'b0001111: w_code = 4'h7;
            7'b0000000: w_code = 4'h8;
            7'b0000100: w_code = 4'h9;
            7'b1111111: begin
                w_code      = 4'hF;
                w_blank_bit = 1'b1;
            end
            default: begin
                w_code    = 4'hE;
                w_err_bit = 1'b1;
            end
        endcase
    end

    // Shadow update and frame completion
    always_comb begin
        w_sh_digits_d = r_sh_digits;
        w_sh_blank_d  = r_sh_blank;
        w_sh_err_d    = r_sh_err;
        w_seen_d      = r_seen;
        w_publish     = 1'b0;
        if (w_capture && w_one_hot) begin
            w_sh_digits_d[{w_slot, 2'b00} +: 4] = w_code;
            w_sh_blank_d[w_slot]                = w_blank_bit;
            w_sh_err_d[w_slot]                  = w_err_bit;
            if ((r_seen | w_an_low) == 8'hFF) begin
                w_publish = 1'b1;
                w_seen_d  = 8'h00;
            end else begin
                w_seen_d  = r_seen | w_an_low;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= IdleSample;
            r_cnt    <= 8'd0;
            r_done   <= 1'b0;
        end else begin
            r_sample <= w_sample;
            if (!w_same) begin
                r_cnt  <= 8'd0;
                r_done <= 1'b0;
            end else begin
                if (r_cnt < CntMax) begin
                    r_cnt <= r_cnt + 8'd1;
                end
                if (w_capture) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_digits   <= 32'h0;
            r_sh_blank    <= 8'h00;
            r_sh_err      <= 8'h00;
            r_seen        <= 8'h00;
            r_digits      <= 32'h0;
            r_blank       <= 8'h00;
            r_err         <= 8'h00;
            r_frame_valid <= 1'b0;
            r_an_err      <= 1'b0;
        end else begin
            r_sh_digits   <= w_sh_digits_d;
            r_sh_blank    <= w_sh_blank_d;
            r_sh_err      <= w_sh_err_d;
            r_seen        <= w_seen_d;
            r_frame_valid <= w_publish;
            r_an_err      <= w_capture && w_multi;
            // Publish includes the slot captured on this very edge.
            if (w_publish) begin
                r_digits <= w_sh_digits_d;
                r_blank  <= w_sh_blank_d;
                r_err    <= w_sh_err_d;
            end
        end
    end

    assign digits      = r_digits;
    assign blank       = r_blank;
    assign err         = r_err;
    assign frame_valid = r_frame_valid;
    assign an_err      = r_an_err;

endmodule

// File: tb/tb_seg_capture.sv
// Testbench for seg_capture: table of bus dwell steps with expected cumulative pulse
// counts and published outputs, plus hand-written reset sequences.
module tb_seg_capture;

    localparam int OpDrive    = 0;
    localparam int OpRstPulse = 1;
    localparam int OpAsyncRst = 2;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [7:0]  an_in;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  err;
    logic        frame_valid;
    logic        an_err;

    seg_capture #(
        .STABLE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .digits     (digits),
        .blank      (blank),
        .err        (err),
        .frame_valid(frame_valid),
        .an_err     (an_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [6:0]  seg;
        logic [7:0]  an;
        int          hold;
        int          pk;       // expected sample index of a pulse in this step, -1 = none
        bit          chk;
        int          exp_fv;   // cumulative frame_valid pulses
        int          exp_aerr; // cumulative an_err pulses
        logic [31:0] exp_dig;
        logic [7:0]  exp_blk;
        logic [7:0]  exp_err;
    } vec_t;

    logic [6:0] seg_tab [10];
    vec_t       vecs[$];

    int          n_checks;
    int          n_fail;
    int          fv_cnt;
    int          aerr_cnt;
    int          bad_cnt;
    logic [47:0] prev_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_raw(input logic [6:0] seg, input logic [7:0] an,
                                    input int hold, input int pk);
        vec_t v;
        v.op = OpDrive; v.seg = seg; v.an = an; v.hold = hold; v.pk = pk; v.chk = 1'b0;
        v.exp_fv = 0; v.exp_aerr = 0; v.exp_dig = 32'h0; v.exp_blk = 8'h0; v.exp_err = 8'h0;
        return v;
    endfunction

    function automatic vec_t mk_slot(input int slot, input int val, input int pk);
        return mk_raw(seg_tab[val], ~(8'(1) << slot), 6, pk);
    endfunction

    function automatic vec_t mk_chk(input int hold, input int fv, input int aerr,
                                    input logic [31:0] dig, input logic [7:0] blk,
                                    input logic [7:0] er);
        vec_t v;
        v = mk_raw(7'h7F, 8'hFF, hold, -1);
        v.chk = 1'b1; v.exp_fv = fv; v.exp_aerr = aerr;
        v.exp_dig = dig; v.exp_blk = blk; v.exp_err = er;
        return v;
    endfunction

    function automatic vec_t mk_op(input int op);
        vec_t v;
        v = mk_raw(7'h7F, 8'hFF, 1, -1);
        v.op = op;
        return v;
    endfunction

    // Observe outputs produced by the previous rising edge.
    task automatic sample(input int k, inout int pulse_k);
        if (frame_valid) begin
            fv_cnt++;
            pulse_k = k;
        end
        if (an_err) begin
            aerr_cnt++;
            pulse_k = k;
        end
        if (frame_valid && an_err) bad_cnt++;
        if (!frame_valid && ({digits, blank, err} !== prev_out)) bad_cnt++;
        prev_out = {digits, blank, err};
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int pulse_k;
        pulse_k = -1;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            sample(k, pulse_k);
            if (k == 0) begin
                seg_in = v.seg;
                an_in  = v.an;
            end
        end
        if (v.pk >= 0) check($sformatf("pulse_edge[%0d]", idx), pulse_k, v.pk);
        if (v.chk) begin
            check($sformatf("fv_count[%0d]", idx), fv_cnt, v.exp_fv);
            check($sformatf("an_err_count[%0d]", idx), aerr_cnt, v.exp_aerr);
            check($sformatf("digits[%0d]", idx), digits, v.exp_dig);
            check($sformatf("blank[%0d]", idx), {24'h0, blank}, {24'h0, v.exp_blk});
            check($sformatf("err[%0d]", idx), {24'h0, err}, {24'h0, v.exp_err});
            check($sformatf("stray_change[%0d]", idx), bad_cnt, 0);
        end
    endtask

    // Reset pulse between captures, bus idle so nothing is pending on release.
    task automatic rst_pulse();
        @(negedge clk);
        seg_in = 7'h7F;
        an_in  = 8'hFF;
        rst_n  = 1'b0;
        #2;
        rst_n  = 1'b1;
        prev_out = 48'h0;
    endtask

    // Assert reset in the middle of the high phase and check outputs clear at once.
    task automatic async_rst_check();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_digits", digits, 32'h0);
        check("async_rst_blank", {24'h0, blank}, 32'h0);
        check("async_rst_err", {24'h0, err}, 32'h0);
        check("async_rst_fv", {31'h0, frame_valid}, 32'h0);
        check("async_rst_an_err", {31'h0, an_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_out = 48'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;
        n_checks = 0; n_fail = 0; fv_cnt = 0; aerr_cnt = 0; bad_cnt = 0;
        prev_out = 48'h0;

        // Idle bus after reset: nothing published
        vecs.push_back(mk_chk(10, 0, 0, 32'h0, 8'h00, 8'h00));
        // Full frame, values 1..8 in slots 0..7; nothing visible until slot 7
        for (int s = 0; s < 7; s++) vecs.push_back(mk_slot(s, s + 1, -1));
        vecs.push_back(mk_chk(2, 0, 0, 32'h0, 8'h00, 8'h00));
        vecs.push_back(mk_slot(7, 8, 5));
        vecs.push_back(mk_chk(2, 1, 0, 32'h87654321, 8'h00, 8'h00));
        // Glitch: a 4-edge dwell is too short to capture
        vecs.push_back(mk_raw(seg_tab[5], 8'hFE, 4, -1));
        vecs.push_back(mk_slot(0, 3, -1));
        for (int s = 1; s < 7; s++) vecs.push_back(mk_slot(s, 0, -1));
        vecs.push_back(mk_slot(7, 0, 5));
        vecs.push_back(mk_chk(2, 2, 0, 32'h00000003, 8'h00, 8'h00));
        // Blank and undecodable patterns
        vecs.push_back(mk_slot(0, 9, -1));
        vecs.push_back(mk_slot(1, 9, -1));
        vecs.push_back(mk_raw(7'b1111111, 8'hFB, 6, -1));
        vecs.push_back(mk_raw(7'b1010101, 8'hF7, 6, -1));
        for (int s = 4; s < 8; s++) vecs.push_back(mk_slot(s, 9, -1));
        vecs.push_back(mk_chk(2, 3, 0, 32'h9999EF99, 8'h04, 8'h08));
        // Multi-select held 10 cycles: one an_err, slot 2 must not count as seen
        vecs.push_back(mk_raw(seg_tab[4], 8'b11110011, 10, 5));
        vecs.push_back(mk_chk(2, 3, 1, 32'h9999EF99, 8'h04, 8'h08));
        for (int s = 0; s < 8; s++) begin
            if (s != 2) vecs.push_back(mk_slot(s, 6, -1));
        end
        vecs.push_back(mk_chk(2, 3, 1, 32'h9999EF99, 8'h04, 8'h08));
        vecs.push_back(mk_slot(2, 2, 5));
        vecs.push_back(mk_chk(2, 4, 1, 32'h66666266, 8'h00, 8'h00));
        // Async reset mid-cycle, then an idle bus must stay quiet
        vecs.push_back(mk_op(OpAsyncRst));
        vecs.push_back(mk_chk(8, 4, 1, 32'h0, 8'h00, 8'h00));
        // Reset mid-frame discards slots 0..4
        for (int s = 0; s < 5; s++) vecs.push_back(mk_slot(s, 1, -1));
        vecs.push_back(mk_op(OpRstPulse));
        for (int s = 5; s < 8; s++) vecs.push_back(mk_slot(s, 7, -1));
        vecs.push_back(mk_chk(2, 4, 1, 32'h0, 8'h00, 8'h00));
        for (int s = 0; s < 4; s++) vecs.push_back(mk_slot(s, 1, -1));
        vecs.push_back(mk_slot(4, 1, 5));
        vecs.push_back(mk_chk(2, 5, 1, 32'h77711111, 8'h00, 8'h00));

        // Power-on reset
        rst_n  = 1'b0;
        seg_in = 7'h7F;
        an_in  = 8'hFF;
        #3;
        check("reset_digits", digits, 32'h0);
        check("reset_blank", {24'h0, blank}, 32'h0);
        check("reset_err", {24'h0, err}, 32'h0);
        check("reset_fv", {31'h0, frame_valid}, 32'h0);
        check("reset_an_err", {31'h0, an_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OpRstPulse: rst_pulse();
                OpAsyncRst: async_rst_check();
                default:    run_vec(vecs[i], i);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
